jtbubl_sdram_sched: RTL and testbench
=====================================

JTBUBL_SDRAM_SCHED -- requirements
Module: jtbubl_sdram_sched

Interface
REQ-001 SHALL have parameter OFF1, default 22'h1_4000, meaning the word offset for slot 1 (sub CPU).
REQ-002 SHALL have parameter OFF2, default 22'h1_C000, meaning the word offset for slot 2 (MCU).
REQ-003 SHALL have parameter OFF3, default 22'h1_8000, meaning the word offset for slot 3 (sound).
REQ-004 SHALL have parameter OFF4, default 22'h2_0000, meaning the word offset for slot 4 (GFX); slot 0 offset is fixed at 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock of the block.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port vblank, input, 1 bit: vertical blank, which enables refresh.
REQ-008 SHALL have port downloading, input, 1 bit: ROM download in progress.
REQ-009 SHALL have port slot_cs, input, 5 bits: per-slot chip select.
REQ-010 SHALL have port slot_addr, input, 110 bits: five packed 22-bit word addresses, slot i at [22i+21:22i].
REQ-011 SHALL have port slot_ok, output, 5 bits: per-slot data valid for the current address.
REQ-012 SHALL have port slot_dout, output, 160 bits: five packed 32-bit cached words.
REQ-013 SHALL have port sdram_req, output, 1 bit: SDRAM read request.
REQ-014 SHALL have port sdram_addr, output, 22 bits: SDRAM word address.
REQ-015 SHALL have port sdram_ack, input, 1 bit: SDRAM has accepted the request.
REQ-016 SHALL have port data_rdy, input, 1 bit: data_read is valid.
REQ-017 SHALL have port data_read, input, 32 bits: SDRAM read data.
REQ-018 SHALL have port refresh_en, output, 1 bit: SDRAM refresh permitted.

Function
REQ-019 SHALL keep, per slot, a one-entry cache holding a 22-bit tag, 32-bit data and a valid bit; slot_dout[i] SHALL be the cached data.
REQ-020 SHALL drive slot_ok[i] combinationally as slot_cs[i] & valid[i] & (tag[i]==slot_addr[i]).
REQ-021 SHALL treat slot i as pending when slot_cs[i] is high and slot_ok[i] is low.
REQ-022 SHALL implement the FSM states IDLE, REQ and WAIT; IDLE goes to REQ when any slot is pending and downloading is low.
REQ-023 SHALL grant by round-robin, searching from (last granted + 1) mod 5 upward; after reset the search SHALL start at slot 0.
REQ-024 SHALL, on IDLE->REQ, register the granted index, capture slot_addr[g] as the tag, and drive sdram_addr = capture + OFF[g] (modulo 2^22) and sdram_req = 1 on the next cycle.
REQ-025 SHALL hold sdram_req and sdram_addr stable in REQ until sdram_ack is sampled high, then clear sdram_req and go to WAIT.
REQ-026 SHALL, in WAIT, on data_rdy write data_read and the captured tag into cache g, set valid[g], and return to IDLE; slot_ok[g] SHALL rise on the following cycle when the address still matches.
REQ-027 SHALL, if sdram_ack and data_rdy are high in the same REQ cycle, complete directly (REQ->IDLE with cache write).
REQ-028 SHALL complete an issued access even when slot_cs[g] falls or slot_addr[g] changes mid-access; the cache SHALL store the captured tag, and a changed address SHALL then miss and re-request.
REQ-029 SHALL ignore data_rdy outside WAIT/REQ.
REQ-030 SHALL, while downloading is high, force the FSM to IDLE, clear sdram_req and all valid bits, and grant nothing.
REQ-031 SHALL drive refresh_en = vblank & (state==IDLE) & ~sdram_req.
REQ-032 SHALL give a minimum miss-to-ok latency of 3 cycles when ack and data_rdy arrive on consecutive cycles after the request.

Reset
REQ-033 SHALL, on rst, set state IDLE, sdram_req 0, sdram_addr 0, all valid bits 0, tags 0, data 0 and the round-robin pointer to slot 4 so that slot 0 is searched first; slot_ok SHALL be 0.
REQ-034 SHALL, on rst asserted mid-access, abandon that access with no cache write and no sdram_req on the cycle after reset.

Verification
REQ-035 SHALL cover: slot 1 cs with addr 0x10 -> sdram_addr 0x14010, sdram_req held until ack, data_rdy with 0xDEADBEEF -> slot_ok[1]=1 and slot_dout[1]=0xDEADBEEF.
REQ-036 SHALL cover: slots 0, 2 and 4 pending simultaneously after reset -> grant order 0, 2, 4; then with slot 0 re-pending and pointer at 4 -> slot 0 next.
REQ-037 SHALL cover: hit repeat, same slot 1 addr 0x10 again -> slot_ok same cycle, no sdram_req.
REQ-038 SHALL cover: slot 4 addr changed from 0x5 to 0x6 during WAIT -> cache tag 0x5 stored, slot_ok[4]=0, new request to 0x20006.
REQ-039 SHALL cover: downloading raised in REQ -> sdram_req 0 next cycle, all slot_ok 0; vblank=1 while idle -> refresh_en=1.
REQ-040 SHALL cover: rst in WAIT followed by data_rdy -> no cache write, slot_ok stays 0.

Source files
------------

// File: rtl/jtbubl_sdram_sched.sv
// Five-slot SDRAM read scheduler. Each slot has a one-word cache, and misses
// are granted round-robin as single-word SDRAM reads.
module jtbubl_sdram_sched #(
    parameter logic [21:0] OFF1 = 22'h1_4000,
    parameter logic [21:0] OFF2 = 22'h1_C000,
    parameter logic [21:0] OFF3 = 22'h1_8000,
    parameter logic [21:0] OFF4 = 22'h2_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vblank,
    input  logic         downloading,
    input  logic [4:0]   slot_cs,
    input  logic [109:0] slot_addr,
    output logic [4:0]   slot_ok,
    output logic [159:0] slot_dout,
    output logic         sdram_req,
    output logic [21:0]  sdram_addr,
    input  logic         sdram_ack,
    input  logic         data_rdy,
    input  logic [31:0]  data_read,
    output logic         refresh_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         req_q, req_d;
    logic [21:0]  addr_q, addr_d;
    logic [2:0]   gnt_q, gnt_d;
    logic [21:0]  cap_q, cap_d;
    logic [21:0]  tag_q  [5];
    logic [21:0]  tag_d  [5];
    logic [31:0]  data_q [5];
    logic [31:0]  data_d [5];
    logic [4:0]   valid_q, valid_d;

    logic [21:0]  addr_a [5];
    logic [4:0]   pend;
    logic [2:0]   pick;
    logic         any_pend;
    logic         wr;

    function automatic logic [21:0] slot_off(input logic [2:0] g);
        case (g)
            3'd1:    slot_off = OFF1;
            3'd2:    slot_off = OFF2;
            3'd3:    slot_off = OFF3;
            3'd4:    slot_off = OFF4;
            default: slot_off = 22'd0;
        endcase
    endfunction

    // Slot index k positions after ptr, wrapping within 0..4.
    function automatic logic [2:0] rr_idx(input logic [2:0] ptr, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, ptr} + {1'b0, k};
        if (s >= 4'd5) s = s - 4'd5;
        return s[2:0];
    endfunction

    for (genvar i = 0; i < 5; i++) begin : g_slot
        assign addr_a[i]            = slot_addr[22*i +: 22];
        assign slot_ok[i]           = slot_cs[i] & valid_q[i] & (tag_q[i] == addr_a[i]);
        assign slot_dout[32*i +: 32] = data_q[i];
    end

    assign pend       = slot_cs & ~slot_ok;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = vblank & (state_q == IDLE) & ~req_q;

    // Scanning from the farthest candidate down lets the nearest pending slot win.
    always_comb begin
        any_pend = 1'b0;
        pick     = gnt_q;
        for (int k = 5; k >= 1; k--) begin
            if (pend[rr_idx(gnt_q, 3'(k))]) begin
                pick     = rr_idx(gnt_q, 3'(k));
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        cap_d   = cap_q;
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        wr      = 1'b0;
        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_pend) begin
                        state_d = REQ;
                        gnt_d   = pick;
                        cap_d   = addr_a[pick];
                        addr_d  = addr_a[pick] + slot_off(pick);
                        req_d   = 1'b1;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        if (data_rdy) begin
                            wr      = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        wr      = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // The cache keeps the captured tag even if the slot address moved meanwhile.
        if (wr) begin
            tag_d[gnt_q]   = cap_q;
            data_d[gnt_q]  = data_read;
            valid_d[gnt_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= 22'd0;
            gnt_q   <= 3'd4;
            cap_q   <= 22'd0;
            valid_q <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                tag_q[i]  <= 22'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            for (int i = 0; i < 5; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_jtbubl_sdram_sched.sv
// Directed bench for jtbubl_sdram_sched: issued SDRAM addresses are checked
// against a queue of expected requests by an independent monitor.
module tb_jtbubl_sdram_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         vblank;
    logic         downloading;
    logic [4:0]   slot_cs;
    logic [109:0] slot_addr;
    logic [4:0]   slot_ok;
    logic [159:0] slot_dout;
    logic         sdram_req;
    logic [21:0]  sdram_addr;
    logic         sdram_ack;
    logic         data_rdy;
    logic [31:0]  data_read;
    logic         refresh_en;

    int           errors = 0;
    int           checks = 0;
    logic [21:0]  exp_q [$];
    logic         req_prev = 1'b0;

    always #5 clk = ~clk;

    jtbubl_sdram_sched dut (
        .clk         (clk),
        .rst         (rst),
        .vblank      (vblank),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [21:0] a);
        slot_addr[22*i +: 22] = a;
    endtask

    function automatic logic [31:0] dout(input int i);
        return slot_dout[32*i +: 32];
    endfunction

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(sdram_req), 32'd1);
    endtask

    task automatic serve(input logic [31:0] d);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    // Request monitor: each new sdram_req must match the next expected address.
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clk);
            if (sdram_req && !req_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got addr %h, expected no request", sdram_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (sdram_addr !== e) begin
                        errors++;
                        $display("FAIL req_addr: got %h, expected %h", sdram_addr, e);
                    end
                end
            end
            req_prev = sdram_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; vblank = 1'b0; downloading = 1'b0;
        slot_cs = 5'd0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'd0;
        repeat (3) tick();
        chk("rst_ok",      32'(slot_ok), 32'd0);
        chk("rst_req",     32'(sdram_req), 32'd0);
        chk("rst_addr",    32'(sdram_addr), 32'd0);
        chk("rst_dout1",   dout(1), 32'd0);
        chk("rst_refresh", 32'(refresh_en), 32'd0);
        rst = 1'b0;
        tick();

        // Single miss on slot 1, request held until ack
        exp_q.push_back(22'h14010);
        slot_cs = 5'b00010;
        set_addr(1, 22'h10);
        wait_req("t1_req");
        chk("t1_addr", 32'(sdram_addr), 32'h14010);
        tick(); tick();
        chk("t1_hold_req",  32'(sdram_req), 32'd1);
        chk("t1_hold_addr", 32'(sdram_addr), 32'h14010);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("t1_ack_clear", 32'(sdram_req), 32'd0);
        chk("t1_not_ok",    32'(slot_ok), 32'd0);
        data_rdy = 1'b1; data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        chk("t1_ok",   32'(slot_ok), 32'h02);
        chk("t1_dout", dout(1), 32'hDEADBEEF);

        // Hit repeat: no new request
        repeat (4) tick();
        chk("hit_req", 32'(sdram_req), 32'd0);
        chk("hit_ok",  32'(slot_ok), 32'h02);

        // Round-robin from reset: 0, 2, 4
        rst = 1'b1;
        tick();
        chk("rst_clears_cache", 32'(slot_ok), 32'd0);
        slot_cs = 5'b10101;
        set_addr(0, 22'h100); set_addr(2, 22'h200); set_addr(4, 22'h300);
        exp_q.push_back(22'h00100);
        exp_q.push_back(22'h1C200);
        exp_q.push_back(22'h20300);
        rst = 1'b0;
        wait_req("rr0"); serve(32'h11111111);
        wait_req("rr2"); serve(32'h22222222);
        wait_req("rr4"); serve(32'h44444444);
        tick();
        chk("rr_ok",    32'(slot_ok), 32'h15);
        chk("rr_dout0", dout(0), 32'h11111111);
        chk("rr_dout2", dout(2), 32'h22222222);
        chk("rr_dout4", dout(4), 32'h44444444);

        // Pointer at 4: slot 0 wins over slot 2
        set_addr(0, 22'h101); set_addr(2, 22'h201);
        exp_q.push_back(22'h00101);
        exp_q.push_back(22'h1C201);
        wait_req("wrap0");
        chk("wrap_first", 32'(sdram_addr), 32'h00101);
        serve(32'hA0A0A0A0);
        wait_req("wrap2"); serve(32'hA2A2A2A2);
        tick();
        chk("wrap_ok", 32'(slot_ok), 32'h15);

        // Ack and data in the same cycle
        slot_cs = 5'b00001;
        set_addr(0, 22'h50);
        exp_q.push_back(22'h00050);
        wait_req("same_req");
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h12345678;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("same_req_clr", 32'(sdram_req), 32'd0);
        chk("same_ok",      32'(slot_ok), 32'h01);
        chk("same_dout",    dout(0), 32'h12345678);

        // Slot 4 address changes during WAIT
        slot_cs = 5'b10000;
        set_addr(4, 22'h5);
        exp_q.push_back(22'h20005);
        wait_req("chg_req");
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(4, 22'h6);
        data_rdy = 1'b1; data_read = 32'h55555555;
        exp_q.push_back(22'h20006);
        tick();
        data_rdy = 1'b0;
        chk("chg_miss", 32'(slot_ok), 32'd0);
        chk("chg_dout", dout(4), 32'h55555555);
        wait_req("chg_rereq");
        chk("chg_rereq_addr", 32'(sdram_addr), 32'h20006);
        set_addr(4, 22'h5);
        #1;
        chk("chg_old_tag", 32'(slot_ok), 32'h10);
        serve(32'h66666666);
        set_addr(4, 22'h6);
        #1;
        chk("chg_new_ok",   32'(slot_ok), 32'h10);
        chk("chg_new_dout", dout(4), 32'h66666666);

        // Refresh gating and download abort
        vblank = 1'b1;
        #1;
        chk("refresh_idle", 32'(refresh_en), 32'd1);
        slot_cs = 5'b11000;
        set_addr(3, 22'h7);
        exp_q.push_back(22'h18007);
        wait_req("dl_req");
        chk("refresh_busy", 32'(refresh_en), 32'd0);
        downloading = 1'b1;
        tick();
        chk("dl_req_clr", 32'(sdram_req), 32'd0);
        chk("dl_ok",      32'(slot_ok), 32'd0);
        chk("dl_refresh", 32'(refresh_en), 32'd1);
        repeat (3) tick();
        chk("dl_no_grant", 32'(sdram_req), 32'd0);
        slot_cs = 5'd0; downloading = 1'b0; vblank = 1'b0;
        tick();
        chk("refresh_novb", 32'(refresh_en), 32'd0);

        // Reset during WAIT, then late data
        slot_cs = 5'b00100;
        set_addr(2, 22'h9);
        exp_q.push_back(22'h1C009);
        wait_req("rw_req");
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rst = 1'b1;
        tick();
        chk("rw_no_req", 32'(sdram_req), 32'd0);
        rst = 1'b0;
        data_rdy = 1'b1; data_read = 32'h99999999;
        exp_q.push_back(22'h1C009);
        tick();
        data_rdy = 1'b0;
        chk("rw_ok",   32'(slot_ok), 32'd0);
        chk("rw_dout", dout(2), 32'd0);
        wait_req("rw_rereq");
        serve(32'hAAAAAAAA);
        chk("rw_final_ok",   32'(slot_ok), 32'h04);
        chk("rw_final_dout", dout(2), 32'hAAAAAAAA);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
